// File: rtl/popcnt_seq_pkg.sv
// Shared types and sizing helpers for the sequential population counter.
package popcnt_seq_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} popcnt_seq_state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int calc_accw(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int calc_cntw(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcnt_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0]       bits,
    output logic [$clog2(CHUNK):0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + {{$clog2(CHUNK){1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/popcnt_seq.sv
// Multi-cycle popcount: one CHUNK-bit counter reused over WIDTH/CHUNK cycles.
// Define POPCNT_SEQ_EARLYOUT_EN to finish as soon as the remaining operand bits are zero.
module popcnt_seq
    import popcnt_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] A,
    input  logic             W,
    input  logic             Flush,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] Result
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int ACCW   = calc_accw(WIDTH);
    localparam int CNTW   = calc_cntw(NCHUNK);
    localparam int CW     = $clog2(CHUNK) + 1;

    localparam logic [CNTW-1:0] LAST_FULL = CNTW'(NCHUNK - 1);
    localparam logic [CNTW-1:0] LAST_WORD = CNTW'(NCHUNK / 2 - 1);

    popcnt_seq_state_t state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              w_q, w_d;

    logic [CW-1:0]     chunk_pop;
    logic [WIDTH-1:0]  sh_next;
    logic              last;
    logic              finish;

    popcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits  (sh_q[CHUNK-1:0]),
        .count (chunk_pop)
    );

    assign sh_next = sh_q >> CHUNK;
    assign last    = (cnt_q == (w_q ? LAST_WORD : LAST_FULL));

`ifdef POPCNT_SEQ_EARLYOUT_EN
    assign finish = last || (sh_next == '0);
`else
    assign finish = last;
`endif

    // Flush is applied last so it overrides accept, completion and response handoff.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        w_d     = w_q;

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    state_d = COUNT;
                    sh_d    = W ? {{(WIDTH/2){1'b0}}, A[WIDTH/2-1:0]} : A;
                    acc_d   = '0;
                    cnt_d   = '0;
                    w_d     = W;
                end
            end
            COUNT: begin
                acc_d = acc_q + ACCW'(chunk_pop);
                sh_d  = sh_next;
                cnt_d = cnt_q + CNTW'(1);
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (Flush) begin
            state_d = IDLE;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = (state_q == DONE);
    assign Result    = WIDTH'(acc_q);

endmodule

// File: tb/tb_popcnt_seq.sv
// Scoreboard bench for popcnt_seq (WIDTH=64, CHUNK=16); latency expectations follow POPCNT_SEQ_EARLYOUT_EN.
module tb_popcnt_seq;

`ifdef POPCNT_SEQ_EARLYOUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [63:0] A;
    logic        W;
    logic        Flush;
    logic        RespValid;
    logic        RespReady;
    logic [63:0] Result;

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [63:0] a;
        logic        w;
        logic [63:0] res;
        int          lat_fixed;
        int          lat_early;
    } vec_t;

    vec_t vecs[8];

    popcnt_seq #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .A         (A),
        .W         (W),
        .Flush     (Flush),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .Result    (Result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is consumed on the edge where RespValid and RespReady are both high.
    always @(negedge clk) begin
        if (!reset && RespValid && RespReady) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_resp: got Result 0x%0h, expected no response at %0t", Result, $time);
            end else begin
                checkOutput("result", Result, exp_q.pop_front());
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!ReqReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ReqReady) checkOutput("ready_timeout", {63'd0, ReqReady}, 64'd1);
    endtask

    task automatic waitRespValid(output int n);
        n = 0;
        while (!RespValid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic w, input logic [63:0] res, input int lat);
        int n;
        waitReady();
        ReqValid = 1'b1;
        A        = a;
        W        = w;
        exp_q.push_back(res);
        @(posedge clk); #1;
        ReqValid = 1'b0;
        A        = ~a;
        W        = ~w;
        waitRespValid(n);
        checkOutput("latency", 64'(n), 64'(lat));
        @(posedge clk); #1;
        checkOutput("ready_after_resp", {63'd0, ReqReady}, 64'd1);
        checkOutput("valid_drop", {63'd0, RespValid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd64, 4, 4};
        vecs[1] = '{64'hFFFF_FFFF_0000_0001, 1'b1, 64'd1,  2, 1};
        vecs[2] = '{64'h0000_0000_0000_00FF, 1'b0, 64'd8,  4, 1};
        vecs[3] = '{64'h0000_0000_0000_0000, 1'b0, 64'd0,  4, 1};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b0, 64'd32, 4, 4};
        vecs[5] = '{64'h0123_4567_89AB_CDEF, 1'b1, 64'd20, 2, 2};
        vecs[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'd32, 4, 4};
        vecs[7] = '{64'hFFFF_FFFF_0000_0000, 1'b1, 64'd0,  2, 1};

        reset     = 1'b1;
        ReqValid  = 1'b0;
        A         = '0;
        W         = 1'b0;
        Flush     = 1'b0;
        RespReady = 1'b1;
        #12;
        checkOutput("reset_req_ready", {63'd0, ReqReady}, 64'd1);
        checkOutput("reset_resp_valid", {63'd0, RespValid}, 64'd0);
        checkOutput("reset_result", Result, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].w, vecs[i].res,
                          EARLY ? vecs[i].lat_early : vecs[i].lat_fixed);
        end

        // Backpressure: response held while a second request waits
        RespReady = 1'b0;
        waitReady();
        ReqValid = 1'b1;
        A        = 64'h8000_0000_0000_0000;
        W        = 1'b0;
        exp_q.push_back(64'd1);
        @(posedge clk); #1;
        A = 64'h3;
        waitRespValid(n);
        checkOutput("hold_latency", 64'(n), 64'd4);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_valid", {63'd0, RespValid}, 64'd1);
            checkOutput("hold_result", Result, 64'd1);
            checkOutput("hold_req_ready", {63'd0, ReqReady}, 64'd0);
            @(posedge clk); #1;
        end
        RespReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_handoff", {63'd0, ReqReady}, 64'd1);
        exp_q.push_back(64'd2);
        @(posedge clk); #1;
        checkOutput("held_req_accepted", {63'd0, ReqReady}, 64'd0);
        ReqValid = 1'b0;
        waitRespValid(n);
        checkOutput("held_req_latency", 64'(n), EARLY ? 64'd1 : 64'd4);
        @(posedge clk); #1;

        // Flush in the second COUNT cycle
        waitReady();
        ReqValid = 1'b1;
        A        = 64'hFFFF_FFFF_FFFF_FFFF;
        W        = 1'b0;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        checkOutput("flush_req_ready", {63'd0, ReqReady}, 64'd1);
        checkOutput("flush_resp_valid", {63'd0, RespValid}, 64'd0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        applyStimulus(64'h0F, 1'b0, 64'd4, EARLY ? 1 : 4);

        // Asynchronous reset in the middle of COUNT
        waitReady();
        ReqValid = 1'b1;
        A        = 64'hFFFF_FFFF_FFFF_FFFF;
        W        = 1'b0;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_resp_valid", {63'd0, RespValid}, 64'd0);
        checkOutput("async_rst_result", Result, 64'd0);
        checkOutput("async_rst_req_ready", {63'd0, ReqReady}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(64'h3, 1'b0, 64'd2, EARLY ? 1 : 4);

        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
